// File: rtl/cu_multi_cycle_main_fsm.sv
// -----------------------------------------------------------------------------
// cu_multi_cycle_main_fsm
//   Main control FSM of the multi-cycle RV32I core. Steps every instruction
//   through fetch / decode / execute / memory / writeback, drives the datapath
//   mux selects and write enables, and hands a 2-bit alu_op to the ALU decoder.
//   Supported: LW, SW, R-type, I-type ALU, BEQ/BNE, JAL.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode, funct3      instruction fields from the instruction register
//   zero                ALU zero flag (branch resolution)
//   mem_ready           memory handshake (only with CU_MC_MEM_WAIT_EN)
//   pc_write            PC enable = pc_update | (branch & take)
//   adr_src             memory address select (0 PC, 1 alu_out)
//   mem_write           data memory write enable
//   ir_write            instruction register / old-PC latch enable
//   result_src          result mux (00 alu_out, 01 mem data, 10 alu_result)
//   alu_src_a/b         ALU operand muxes
//   alu_op              00 add, 01 sub, 10 funct-decoded
//   reg_write           register file write enable
//   instr_done          pulse in the final state of each instruction
//   illegal_instr       pulse in DECODE for an unsupported opcode
//   dbg_state           current state encoding
//
// Build option
//   CU_MC_MEM_WAIT_EN   when defined, FETCH, MEMREAD and MEMWRITE wait for
//                       mem_ready; otherwise mem_ready is ignored.
// -----------------------------------------------------------------------------
module cu_multi_cycle_main_fsm #(
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [6:0]         opcode,
   input  logic [2:0]         funct3,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               adr_src,
   output logic               mem_write,
   output logic               ir_write,
   output logic [1:0]         result_src,
   output logic [1:0]         alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               reg_write,
   output logic               instr_done,
   output logic               illegal_instr,
   output logic [STATE_W-1:0] dbg_state
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH    = STATE_W'(0),
      S_DECODE   = STATE_W'(1),
      S_MEMADR   = STATE_W'(2),
      S_MEMREAD  = STATE_W'(3),
      S_MEMWB    = STATE_W'(4),
      S_MEMWRITE = STATE_W'(5),
      S_EXECUTER = STATE_W'(6),
      S_EXECUTEI = STATE_W'(7),
      S_ALUWB    = STATE_W'(8),
      S_JAL      = STATE_W'(9),
      S_BRANCH   = STATE_W'(10)
   } state_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   state_t state_q, state_d;

   // Handshake qualifier for the waiting states; constant 1 when disabled.
   logic mem_go;
`ifdef CU_MC_MEM_WAIT_EN
   assign mem_go = mem_ready;
`else
   assign mem_go = 1'b1;
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
`endif

   logic legal_op;
   assign legal_op = (opcode == OP_LW)    || (opcode == OP_SW)    ||
                     (opcode == OP_RTYPE) || (opcode == OP_ITYPE) ||
                     (opcode == OP_BRANCH)|| (opcode == OP_JAL);

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = mem_go ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTER;
               OP_ITYPE:     state_d = S_EXECUTEI;
               OP_BRANCH:    state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = mem_go ? S_MEMWB : S_MEMREAD;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = mem_go ? S_FETCH : S_MEMWRITE;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         default:    state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // ------------------------------------------------------------ output decode
   logic pc_update, branch, take;
   logic ir_write_c, mem_write_c, reg_write_c, instr_done_c, illegal_c;

   always_comb begin
      pc_update    = 1'b0;
      branch       = 1'b0;
      ir_write_c   = 1'b0;
      mem_write_c  = 1'b0;
      reg_write_c  = 1'b0;
      instr_done_c = 1'b0;
      illegal_c    = 1'b0;
      adr_src      = 1'b0;
      result_src   = 2'b00;
      alu_src_a    = 2'b00;
      alu_src_b    = 2'b00;
      alu_op       = 2'b00;
      case (state_q)
         S_FETCH: begin
            ir_write_c = mem_go;
            pc_update  = mem_go;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            illegal_c = !legal_op;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            adr_src = 1'b1;
         end
         S_MEMWB: begin
            result_src   = 2'b01;
            reg_write_c  = 1'b1;
            instr_done_c = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src      = 1'b1;
            mem_write_c  = 1'b1;
            instr_done_c = mem_go;
         end
         S_EXECUTER: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECUTEI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_write_c  = 1'b1;
            instr_done_c = 1'b1;
         end
         S_JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_update = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a    = 2'b10;
            alu_op       = 2'b01;
            branch       = 1'b1;
            instr_done_c = 1'b1;
         end
         default: ;
      endcase
   end

   // Unsupported funct3 under the branch opcode never takes the branch.
   always_comb begin
      case (funct3)
         3'b000:  take = zero;
         3'b001:  take = !zero;
         default: take = 1'b0;
      endcase
   end

   // Enables are gated by rst_n so nothing fires while reset is held, even
   // though the state register already shows FETCH.
   assign pc_write      = rst_n & (pc_update | (branch & take));
   assign ir_write      = rst_n & ir_write_c;
   assign mem_write     = rst_n & mem_write_c;
   assign reg_write     = rst_n & reg_write_c;
   assign instr_done    = rst_n & instr_done_c;
   assign illegal_instr = rst_n & illegal_c;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_cu_multi_cycle_main_fsm.sv
module tb_cu_multi_cycle_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic       instr_done, illegal_instr;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
   logic [3:0] dbg_state;

   int checks = 0;
   int failures = 0;

`ifdef CU_MC_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   cu_multi_cycle_main_fsm #(.STATE_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_write(reg_write), .instr_done(instr_done),
      .illegal_instr(illegal_instr), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   // One cycle: drive on the falling edge, sample 1ns later.
   task automatic step(input logic [6:0] opc, input logic [2:0] f3,
                       input logic z, input logic mr);
      @(negedge clk);
      opcode = opc; funct3 = f3; zero = z; mem_ready = mr;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [18:0] act_vec();
      return {dbg_state, pc_write, adr_src, mem_write, ir_write, reg_write,
              instr_done, illegal_instr, result_src, alu_src_a, alu_src_b, alu_op};
   endfunction

   // ---------------- reference model: per instruction kind, per phase --------
   // kinds: 0 LW, 1 SW, 2 R, 3 I, 4 JAL, 5 BRANCH, 6 illegal
   function automatic int ilen(input int k);
      case (k)
         0: return 5;
         1, 2, 3, 4: return 4;
         5: return 3;
         default: return 2;
      endcase
   endfunction

   function automatic bit waitable(input int k, input int ph);
      return (ph == 0) || ((k == 0 || k == 1) && ph == 3);
   endfunction

   function automatic logic [6:0] kind_opc(input int k);
      logic [6:0] tbl [6];
      tbl = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
      return tbl[k];
   endfunction

   function automatic logic [18:0] model(input int k, input int ph, input logic [2:0] f3,
                                         input logic z, input logic stall);
      logic [3:0] st;
      logic pcw, adr, mw, irw, rw, dn, ill;
      logic [1:0] rs, a, b, op;
      st = 0; {pcw, adr, mw, irw, rw, dn, ill} = '0; {rs, a, b, op} = '0;
      if (ph == 0) begin
         st = 0; b = 2; rs = 2; irw = !stall; pcw = !stall;
      end else if (ph == 1) begin
         st = 1; a = 1; b = 1; ill = (k == 6);
      end else if (k == 0 || k == 1) begin
         if (ph == 2) begin st = 2; a = 2; b = 1; end
         else if (k == 1) begin st = 5; adr = 1; mw = 1; dn = !stall; end
         else if (ph == 3) begin st = 3; adr = 1; end
         else begin st = 4; rs = 1; rw = 1; dn = 1; end
      end else if (k == 2 || k == 3 || k == 4) begin
         if (ph == 3) begin st = 8; rw = 1; dn = 1; end
         else if (k == 4) begin st = 9; a = 1; b = 2; pcw = 1; end
         else begin st = (k == 2) ? 4'd6 : 4'd7; a = 2; b = (k == 2) ? 2'd0 : 2'd1; op = 2; end
      end else begin
         st = 10; a = 2; op = 1; dn = 1;
         pcw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
      end
      return {st, pcw, adr, mw, irw, rw, dn, ill, rs, a, b, op};
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      for (int i = 0; i < 6; i++) if (kind_opc(i) == o) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- directed table ------------------------------------------
   typedef struct {
      string      name;
      logic [6:0] opc;
      logic [2:0] f3;
      logic       z;
      int         lat;
      logic       pcw_last;
      logic       ill;
   } vec_t;

   vec_t vecs [11];

   initial begin
      int ncyc;
      logic pcw_seen, ill_seen, wen_seen;
      vecs[0]  = '{"lw",       7'b0000011, 3'b010, 1'b0, 5, 1'b0, 1'b0};
      vecs[1]  = '{"sw",       7'b0100011, 3'b010, 1'b0, 4, 1'b0, 1'b0};
      vecs[2]  = '{"rtype",    7'b0110011, 3'b000, 1'b0, 4, 1'b0, 1'b0};
      vecs[3]  = '{"itype",    7'b0010011, 3'b111, 1'b1, 4, 1'b0, 1'b0};
      vecs[4]  = '{"jal",      7'b1101111, 3'b000, 1'b0, 4, 1'b0, 1'b0};
      vecs[5]  = '{"beq_z1",   7'b1100011, 3'b000, 1'b1, 3, 1'b1, 1'b0};
      vecs[6]  = '{"beq_z0",   7'b1100011, 3'b000, 1'b0, 3, 1'b0, 1'b0};
      vecs[7]  = '{"bne_z0",   7'b1100011, 3'b001, 1'b0, 3, 1'b1, 1'b0};
      vecs[8]  = '{"bne_z1",   7'b1100011, 3'b001, 1'b1, 3, 1'b0, 1'b0};
      vecs[9]  = '{"br_f3_4",  7'b1100011, 3'b100, 1'b1, 3, 1'b0, 1'b0};
      vecs[10] = '{"illegal",  7'b1111111, 3'b000, 1'b0, 2, 1'b0, 1'b1};

      rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b1;
      #2;
      chk("rst_state", 32'(dbg_state), 0);
      chk("rst_wen", 32'({pc_write, ir_write, mem_write, reg_write, instr_done, illegal_instr}), 0);
      chk("rst_fetch_mux", 32'({adr_src, alu_src_a, alu_src_b, alu_op, result_src}), 32'b0_00_10_00_10);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // ---- table-driven latency / branch / illegal checks
      for (int v = 0; v < 11; v++) begin
         ncyc = 0; pcw_seen = 1'b0; ill_seen = 1'b0; wen_seen = 1'b0;
         for (int c = 1; c <= 8; c++) begin
            step(vecs[v].opc, vecs[v].f3, vecs[v].z, 1'b1);
            if (c == 1) chk({vecs[v].name, "_start"}, 32'(dbg_state), 0);
            if (instr_done || illegal_instr) begin
               ncyc = c; pcw_seen = pc_write; ill_seen = illegal_instr;
               wen_seen = pc_write | ir_write | mem_write | reg_write;
               break;
            end
         end
         chk({vecs[v].name, "_latency"}, 32'(ncyc), 32'(vecs[v].lat));
         chk({vecs[v].name, "_pcw"}, 32'(pcw_seen), 32'(vecs[v].pcw_last));
         chk({vecs[v].name, "_illegal"}, 32'(ill_seen), 32'(vecs[v].ill));
         if (vecs[v].ill) chk({vecs[v].name, "_no_wen"}, 32'(wen_seen), 0);
      end
      step(7'b0110011, 3'b000, 1'b0, 1'b1);
      chk("after_illegal_fetch", 32'(dbg_state), 0);
      do_reset();

`ifdef CU_MC_MEM_WAIT_EN
      // ---- FETCH waits for mem_ready
      for (int c = 0; c < 3; c++) begin
         step(7'b0110011, 3'b000, 1'b0, 1'b0);
         chk("wait_fetch_irw", 32'({dbg_state, ir_write, pc_write}), 32'({4'd0, 2'b00}));
      end
      step(7'b0110011, 3'b000, 1'b0, 1'b1);
      chk("wait_fetch_go", 32'({dbg_state, ir_write, pc_write}), 32'({4'd0, 2'b11}));
      step(7'b0110011, 3'b000, 1'b0, 1'b0);
      chk("wait_decode", 32'({dbg_state, ir_write}), 32'({4'd1, 1'b0}));
      do_reset();
`endif

      // ---- randomized instructions against the model
      for (int n = 0; n < 300; n++) begin
         int k;
         logic [6:0] opc;
         logic [2:0] f3;
         k = $urandom_range(0, 6);
         if (k == 6) begin
            do opc = 7'($urandom_range(0, 127)); while (is_legal(opc));
         end else opc = kind_opc(k);
         f3 = (k == 5) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         for (int ph = 0; ph < ilen(k); ph++) begin
            int guard;
            logic stall, z, mr;
            guard = 0;
            do begin
               z = 1'($urandom_range(0, 1));
               mr = WAIT_EN ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
               stall = WAIT_EN && waitable(k, ph) && !mr;
               step(opc, f3, z, mr);
               chk("rand_cycle", 32'(act_vec()), 32'(model(k, ph, f3, z, stall)));
               guard++;
               if (guard > 20) begin
                  chk("rand_stall_bound", 32'(guard), 20);
                  break;
               end
            end while (stall);
         end
      end

      // ---- reset asserted in the middle of MEMREAD
      for (int ph = 0; ph < 4; ph++) step(7'b0000011, 3'b010, 1'b0, 1'b1);
      chk("lw_in_memread", 32'({dbg_state, reg_write}), 32'({4'd3, 1'b0}));
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_state", 32'(dbg_state), 0);
      chk("midrst_wen", 32'({pc_write, ir_write, mem_write, reg_write, instr_done, illegal_instr}), 0);
      chk("midrst_mux", 32'({alu_src_b, result_src}), 32'b10_10);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(7'b0000011, 3'b010, 1'b0, 1'b1);
      chk("midrst_rel_fetch", 32'({dbg_state, ir_write, reg_write}), 32'({4'd0, 2'b10}));
      step(7'b0000011, 3'b010, 1'b0, 1'b1);
      chk("midrst_rel_decode", 32'(dbg_state), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
